// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream raster frame source.
//
// Emits FRAME_WIDTH x FRAME_HEIGHT pixel frames. tuser marks pixel (0,0) and
// tlast marks the last pixel of every line. The pixel pattern is one of
// ramp / LFSR / constant / checkerboard. Downstream backpressure is honoured.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle frame request (acted on only in IDLE)
//   continuous            repeat frames back-to-back while high
//   pattern_sel[1:0]      0 ramp, 1 LFSR, 2 constant, 3 checkerboard
//   seed[15:0]            LFSR seed / constant value
//   m_axis_*              AXI4-Stream master (tvalid/tready/tdata/tlast/tuser)
//   busy                  high outside IDLE
//   frame_done            one-cycle pulse after the final handshake of a frame
//   frame_cnt[15:0]       completed frame counter (wraps)
//
// state  | meaning
// IDLE   | waiting for start
// ACTIVE | presenting pixels on the stream
// LGAP   | idle cycles between lines
// FGAP   | idle cycles after the last pixel of a frame

module axis_frame_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 20,
  parameter int FRAME_HEIGHT = 20,
  parameter int LINE_GAP     = 0,
  parameter int FRAME_GAP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [1:0]            pattern_sel,
  input  logic [15:0]           seed,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, LGAP, FGAP} state_t;

  localparam int CW   = $clog2(FRAME_WIDTH);
  localparam int RW   = $clog2(FRAME_HEIGHT);
  localparam int GMAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GW   = $clog2(GMAX + 2);

  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [GW-1:0] LG_LOAD  = (LINE_GAP  > 0) ? GW'(LINE_GAP - 1)  : '0;
  localparam logic [GW-1:0] FG_LOAD  = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [1:0]            pat_q, pat_d;
  logic [DATA_WIDTH-1:0] const_q, const_d;
  logic [GW-1:0]         gap_q, gap_d;

  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  load;
  logic                  hs;

  assign hs = tvalid_q && m_axis_tready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    const_d = const_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (hs) begin
          lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              done_d  = 1'b1;
              cnt_d   = cnt_q + 16'd1;
              gap_d   = FG_LOAD;
              state_d = FGAP;
            end else begin
              row_d = row_q + RW'(1);
              if (LINE_GAP > 0) begin
                gap_d   = LG_LOAD;
                state_d = LGAP;
              end
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      LGAP: begin
        if (gap_q == '0) state_d = ACTIVE;
        else             gap_d   = gap_q - GW'(1);
      end
      FGAP: begin
        // With FRAME_GAP = 0 this state still lasts one cycle: it is where
        // the continue-or-stop decision is taken.
        if (gap_q == '0) begin
          if (continuous) begin
            load    = 1'b1;
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: configuration is captured here and held for the frame.
    if (load) begin
      pat_d   = pattern_sel;
      const_d = seed[DATA_WIDTH-1:0];
      row_d   = '0;
      col_d   = '0;
      lfsr_d  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    end

    // Outputs are computed from next-state values so that they are registered
    // and line up with the pixel being presented.
    tvalid_d = (state_d == ACTIVE);
    busy_d   = (state_d != IDLE);
    tlast_d  = tvalid_d && (col_d == COL_LAST);
    tuser_d  = tvalid_d && (row_d == '0) && (col_d == '0);
    tdata_d  = '0;
    if (tvalid_d) begin
      case (pat_d)
        2'd0:    tdata_d = DATA_WIDTH'(row_d) + DATA_WIDTH'(col_d);
        2'd1:    tdata_d = lfsr_d[DATA_WIDTH-1:0];
        2'd2:    tdata_d = const_d;
        default: tdata_d = {DATA_WIDTH{row_d[0] ^ col_d[0]}};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      lfsr_q   <= '0;
      pat_q    <= '0;
      const_q  <= '0;
      gap_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      lfsr_q   <= lfsr_d;
      pat_q    <= pat_d;
      const_q  <= const_d;
      gap_q    <= gap_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_cnt     = cnt_q;

endmodule
